ram2_req_sequencer: RTL and testbench

- Request front-end placed directly upstream of the single-port 64-bit synchronous RAM `ram2`.
- After reset, it zero-fills every RAM word.
- It then converts a valid/ready request stream (read or write) into `ram2`'s `sel`/`we`/`adr`/`dat_i` strobes.
- It captures the RAM's 1-cycle registered read data into a 3-entry response buffer with valid/ready backpressure.

---
 rtl/ram2_seq_pkg.sv | 24 ++
 rtl/ram2_req_sequencer_if.sv | 24 ++
 rtl/ram2_rsp_fifo.sv | 56 +++++
 rtl/ram2_req_sequencer.sv | 110 +++++++++++
 tb/tb_ram2_req_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram2_seq_pkg.sv
// rtl/ram2_seq_pkg.sv - shared types and constants for the ram2 request sequencer
package ram2_seq_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int RSP_DEPTH = 3;
    localparam int DEF_SIZE  = 5;
    localparam int DEF_DW    = 64;

    typedef struct packed {
        logic                we;
        logic [DEF_SIZE-1:0] adr;
        logic [DEF_DW-1:0]   dat;
    } req_t;

    // Circular pointer over RSP_DEPTH entries; 2-bit pointer wraps 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RSP_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/ram2_req_sequencer_if.sv
// rtl/ram2_req_sequencer_if.sv - request and response streams of the ram2 sequencer
interface ram2_req_sequencer_if #(
    parameter int SIZE = 5,
    parameter int DW   = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [SIZE-1:0] req_adr;
    logic [DW-1:0]   req_dat;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_dat;

    modport master (
        output req_valid, req_we, req_adr, req_dat, rsp_ready,
        input  req_ready, rsp_valid, rsp_dat
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_dat, rsp_ready,
        output req_ready, rsp_valid, rsp_dat
    );
endinterface

// File: rtl/ram2_rsp_fifo.sv
// rtl/ram2_rsp_fifo.sv - 3-entry response buffer holding RAM read data in order
module ram2_rsp_fifo
    import ram2_seq_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] rd_dat,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem_q [RSP_DEPTH];
    logic [DW-1:0] mem_d [RSP_DEPTH];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Data storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign occ    = occ_q;

endmodule

// File: rtl/ram2_req_sequencer.sv
// rtl/ram2_req_sequencer.sv - zero-fills ram2 after reset, then sequences read/write requests
module ram2_req_sequencer
    import ram2_seq_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int DW   = DEF_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram2_req_sequencer_if.slave   bus,
    output logic                  init_done,
    output logic                  ram_sel,
    output logic                  ram_we,
    output logic [SIZE-1:0]       ram_adr,
    output logic [DW-1:0]         ram_dat_i,
    input  logic [DW-1:0]         ram_dat_o
);

    typedef struct packed {
        logic            we;
        logic [SIZE-1:0] adr;
        logic [DW-1:0]   dat;
    } req_s;

    state_e          state_q, state_d;
    logic [SIZE-1:0] init_cnt_q, init_cnt_d;
    logic            inflight_q, inflight_d;
    logic            req_ready_q, req_ready_d;

    req_s            req;
    logic            accept;
    logic            pop;
    logic            sel_int;
    logic            we_int;
    logic [1:0]      occ;
    logic [2:0]      occ_nxt;

    always_comb begin
        req.we      = bus.req_we;
        req.adr     = bus.req_adr;
        req.dat     = bus.req_dat;
        accept      = (state_q == RUN) && bus.req_valid && req_ready_q;
        pop         = bus.rsp_valid && bus.rsp_ready;
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        inflight_d  = accept && !req.we;
        sel_int     = 1'b0;
        we_int      = 1'b0;
        ram_adr     = req.adr;
        ram_dat_i   = req.dat;
        occ_nxt     = 3'(occ) + 3'(inflight_q) - 3'(pop);

        case (state_q)
            INIT: begin
                sel_int    = 1'b1;
                we_int     = 1'b1;
                ram_adr    = init_cnt_q;
                ram_dat_i  = '0;
                init_cnt_d = init_cnt_q + SIZE'(1);
                if (&init_cnt_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                sel_int = accept;
                we_int  = accept && req.we;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Credit: buffered + in-flight reads (as of next cycle) may never exceed the buffer depth.
        req_ready_d = (state_d == RUN) && ((occ_nxt + 3'(inflight_d)) < 3'(RSP_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            inflight_q  <= inflight_d;
            req_ready_q <= req_ready_d;
        end
    end

    ram2_rsp_fifo #(
        .DW (DW)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_dat (ram_dat_o),
        .pop      (pop),
        .rd_dat   (bus.rsp_dat),
        .occ      (occ)
    );

    // Strobes are gated by reset so the RAM is never touched while it is asserted.
    assign ram_sel       = rst_n && sel_int;
    assign ram_we        = rst_n && we_int;
    assign init_done     = (state_q == RUN);
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (occ != 2'd0);

endmodule

// File: tb/tb_ram2_req_sequencer.sv
// tb/tb_ram2_req_sequencer.sv - scoreboard bench for ram2_req_sequencer with a behavioural RAM
module tb_ram2_req_sequencer;

    localparam int SIZE  = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init_done;
    logic            ram_sel;
    logic            ram_we;
    logic [SIZE-1:0] ram_adr;
    logic [DW-1:0]   ram_dat_i;
    logic [DW-1:0]   ram_dat_o;
    logic            poison = 1'b1;

    logic [DW-1:0]   ram_mem [DEPTH];
    logic [DW-1:0]   ref_mem [DEPTH];
    logic [DW-1:0]   exp_q [$];
    int              checks = 0;
    int              errors = 0;

    ram2_req_sequencer_if #(.SIZE(SIZE), .DW(DW)) bus ();

    ram2_req_sequencer #(.SIZE(SIZE), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .ram_sel   (ram_sel),
        .ram_we    (ram_we),
        .ram_adr   (ram_adr),
        .ram_dat_i (ram_dat_i),
        .ram_dat_o (ram_dat_o)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read; garbage on dat_o when not reading.
    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= {$urandom, $urandom};
        end else if (ram_sel && ram_we) begin
            ram_mem[ram_adr] <= ram_dat_i;
        end
        if (ram_sel && !ram_we) ram_dat_o <= ram_mem[ram_adr];
        else                    ram_dat_o <= {$urandom, $urandom};
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted response must match the oldest expected read.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) chk("rsp_dat", bus.rsp_dat, exp_q.pop_front());
            end
            if (rst_n && init_done && !(bus.req_valid && bus.req_ready))
                chk("idle_sel", ram_sel, 1'b0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic model_accept(input logic we, input logic [SIZE-1:0] adr, input logic [DW-1:0] dat);
        if (we) ref_mem[adr] = dat;
        else    exp_q.push_back(ref_mem[adr]);
    endtask

    task automatic release_and_check_init();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk($sformatf("init_cyc%0d", i),
                {ram_sel, ram_we, ram_adr, ram_dat_i, init_done, bus.req_ready, bus.rsp_valid},
                {1'b1, 1'b1, 5'(i), 64'd0, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        chk("run_entry", {init_done, bus.req_ready}, 2'b11);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic we, input logic [SIZE-1:0] adr, input logic [DW-1:0] dat,
                         output int waits);
        bit ok = 0;
        waits = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_adr   = adr;
        bus.req_dat   = dat;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!ok) chk("req_accept_timeout", waits, 0);
        else begin
            model_accept(we, adr, dat);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        chk(nm, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int acc;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        bus.rsp_ready = 1'b1;

        // Reset with poisoned RAM, then full zero-fill sweep.
        repeat (2) @(posedge clk);
        #1 poison = 1'b0;
        @(posedge clk); #1;
        release_and_check_init();

        issue(1'b0, 5'd31, '0, w);
        wait_drain("drain_rd31");

        // Write then read the same address on the next cycle; 2-cycle latency.
        issue(1'b1, 5'd3, 64'hDEADBEEF_CAFEF00D, w);
        issue(1'b0, 5'd3, '0, w);
        @(negedge clk);
        chk("lat_n1_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_n2_rsp_valid", bus.rsp_valid, 1'b1);
        wait_drain("drain_raw");

        // Fill, then 32 back-to-back reads at full throughput.
        for (int k = 0; k < DEPTH; k++) issue(1'b1, 5'(k), 64'(k) * 64'h0101_0101_0101_0101, w);
        for (int k = 0; k < DEPTH; k++) begin
            issue(1'b0, 5'(k), '0, w);
            chk($sformatf("b2b_wait%0d", k), w, 0);
        end
        wait_drain("drain_b2b");

        // Backpressure: only 3 reads may be accepted while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req_adr = 5'(acc + 7);
            @(negedge clk);
            if (bus.req_ready) begin
                model_accept(1'b0, bus.req_adr, '0);
                acc++;
            end
            @(posedge clk); #1;
        end
        chk("stall_accepts", acc, 3);
        @(negedge clk);
        chk("stall_ready", {bus.req_ready, ram_sel}, 2'b00);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain("drain_stall");
        issue(1'b0, 5'd20, '0, w);
        chk("resume_wait", w, 0);
        wait_drain("drain_resume");

        // Random mix on a narrow address range with random backpressure.
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = ($urandom_range(3) != 0);
            bus.req_we    = $urandom_range(1);
            bus.req_adr   = 5'($urandom_range(7));
            bus.req_dat   = {$urandom, $urandom};
            bus.rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) model_accept(bus.req_we, bus.req_adr, bus.req_dat);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain("drain_random");

        // Reset mid-stream with two buffered responses and one read in flight.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 5'd10, '0, w);
        issue(1'b0, 5'd11, '0, w);
        issue(1'b0, 5'd12, '0, w);
        rst_n  = 1'b0;
        poison = 1'b1;
        bus.req_valid = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_immediate", {bus.rsp_valid, bus.req_ready, ram_sel, ram_we}, 4'b0000);
        @(negedge clk);
        chk("rst_hold1", {bus.rsp_valid, bus.req_ready, ram_sel, ram_we, init_done}, 5'b00000);
        @(posedge clk); #1;
        poison = 1'b0;
        @(negedge clk);
        chk("rst_hold2", {bus.rsp_valid, bus.req_ready, ram_sel, ram_we, init_done}, 5'b00000);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        release_and_check_init();
        issue(1'b0, 5'd10, '0, w);
        issue(1'b0, 5'd11, '0, w);
        issue(1'b0, 5'd12, '0, w);
        wait_drain("drain_after_reset");
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("no_stale_rsp", bus.rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
